// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit qualification, mid-bit sample pulses, stop check and show-ahead FIFO.
// Optional idle/character timeout is built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int FIFO_AW = 2,
  parameter int MIN_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_en,
  input  logic [15:0]        baud_div,
  input  logic               rxd,
  input  logic               rx_neg,
  input  logic               rx_flag,
  input  logic [7:0]         rxdata,
  output logic               rx_int,
  output logic               busy,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               frame_err,
  output logic               overrun,
  input  logic               clr_err,
  output logic               rx_timeout
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] div_q, div_n, div_clamp;
  logic [2:0]  bit_q, bit_n;
  logic        stop_set;

  logic        flag_q, stop_bad, rise, pop, push, full, drop;
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [DEPTH];

  assign div_clamp = (baud_div < 16'(MIN_DIV)) ? 16'(MIN_DIV) : baud_div;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      div_q <= '0;
      bit_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      div_q <= div_n;
      bit_q <= bit_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    div_n    = div_q;
    bit_n    = bit_q;
    rx_int   = 1'b0;
    stop_set = 1'b0;
    case (state)
      IDLE: begin
        if (rx_en && rx_neg) begin
          state_n = START;
          div_n   = div_clamp;
          cnt_n   = (div_clamp >> 1) - 16'd1;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (rxd) begin
            state_n = IDLE;
          end else begin
            rx_int  = 1'b1;
            state_n = DATA;
            cnt_n   = div_q - 16'd1;
            bit_n   = '0;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          rx_int = 1'b1;
          cnt_n  = div_q - 16'd1;
          if (bit_q == 3'd7) state_n = STOP;
          else               bit_n   = bit_q + 3'd1;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          rx_int   = 1'b1;
          stop_set = ~rxd;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A pop in the capture cycle frees the slot, so a full FIFO still accepts the byte.
  assign rise       = rx_flag & ~flag_q;
  assign fifo_level = wr_ptr - rd_ptr;
  assign rd_valid   = (fifo_level != '0);
  assign full       = (fifo_level == (FIFO_AW+1)'(DEPTH));
  assign pop        = rd_en & rd_valid;
  assign push       = rise & ~stop_bad & (~full | pop);
  assign drop       = rise & ~stop_bad & full & ~pop;
  assign rd_data    = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q    <= 1'b0;
      stop_bad  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      flag_q <= rx_flag;
      if (rise)          stop_bad <= 1'b0;
      else if (stop_set) stop_bad <= 1'b1;
      if (push) begin
        mem[wr_ptr[FIFO_AW-1:0]] <= rxdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (rise && stop_bad) frame_err <= 1'b1;
      else if (clr_err)     frame_err <= 1'b0;
      if (drop)             overrun <= 1'b1;
      else if (clr_err)     overrun <= 1'b0;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  logic [31:0] idle_cnt, tmo_limit;
  logic        tmo_q;

  assign tmo_limit  = 32'(div_q) * 32'd40;
  assign rx_timeout = tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      tmo_q    <= 1'b0;
    end else if (push || pop) begin
      idle_cnt <= '0;
      tmo_q    <= 1'b0;
    end else if (state != IDLE) begin
      idle_cnt <= '0;
    end else if (rd_valid && !tmo_q) begin
      idle_cnt <= idle_cnt + 32'd1;
      if (idle_cnt + 32'd1 >= tmo_limit) tmo_q <= 1'b1;
    end
  end
`else
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: emulates the UART_RX datapath, drives 8N1 frames and checks
// pulse timing, FIFO contents and error flags against a queue-based reference.
module tb_uart_rx_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, rx_en = 1'b0, rxd = 1'b1;
  logic        rx_neg, rx_flag = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [15:0] baud_div = 16'd16;
  logic [7:0]  rxdata = 8'h00;
  logic        rx_int, busy, rd_valid, frame_err, overrun, rx_timeout;
  logic [7:0]  rd_data;
  logic [2:0]  fifo_level;

  int tests = 0, fails = 0, cyc = 0, flag_cyc = 0;
  int pulses[$];
  logic [7:0] mq[$];
  bit ferr_m = 0, ovr_m = 0, pop_armed = 0;

  uart_rx_ctrl #(.FIFO_AW(2), .MIN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .baud_div(baud_div), .rxd(rxd),
    .rx_neg(rx_neg), .rx_flag(rx_flag), .rxdata(rxdata), .rx_int(rx_int), .busy(busy),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .fifo_level(fifo_level),
    .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err), .rx_timeout(rx_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART_RX datapath stand-in: falling-edge detect and LSB-first shift on pulses 2..9.
  logic rxd_prev = 1'b1;
  always @(posedge clk) rxd_prev <= rxd;
  assign rx_neg = rxd_prev & ~rxd;

  int pcnt = 0;
  logic [7:0] sh = 8'h00;
  always @(posedge clk) begin
    rx_flag <= 1'b0;
    if (!rst_n) pcnt <= 0;
    else if (rx_int) begin
      if (pcnt >= 1 && pcnt <= 8) sh <= {rxd, sh[7:1]};
      if (pcnt == 9) begin
        rxdata  <= sh;
        rx_flag <= 1'b1;
        pcnt    <= 0;
      end else pcnt <= pcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rx_int) pulses.push_back(cyc);
    if (rx_flag) flag_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    rd_en = 1'b0;
    if (pop_armed && rx_flag) begin
      rd_en = 1'b1;
      pop_armed = 0;
    end
  endtask

  task automatic check_state();
    check("level", fifo_level, mq.size());
    check("valid", rd_valid, mq.size() != 0);
    if (mq.size() != 0) check("head", rd_data, mq[0]);
    check("frame_err", frame_err, ferr_m);
    check("overrun", overrun, ovr_m);
    check("busy_idle", busy, 0);
    check("timeout_off", rx_timeout, 0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit pop_cap,
                            input bit scramble);
    int d, n;
    bit accept;
    d = (baud_div < 16'd4) ? 4 : int'(baud_div);
    accept = rx_en;
    pulses.delete();
    pop_armed = pop_cap;
    step();
    n = cyc;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      rxd = 1'b0;
      else if (k == 9) rxd = stop_bit;
      else             rxd = b[k-1];
      for (int c = 0; c < d; c++) begin
        step();
        if (scramble && k == 0 && c == 0) baud_div = 16'($urandom_range(0, 40));
      end
    end
    rxd = 1'b1;
    repeat (4) step();
    pop_armed = 0;
    if (!accept) begin
      check("pulses_off", pulses.size(), 0);
    end else begin
      check("pulse_cnt", pulses.size(), 10);
      if (pulses.size() == 10)
        for (int k = 0; k < 10; k++) check("pulse_t", pulses[k] - n, d / 2 + k * d);
      if (!stop_bit) ferr_m = 1;
      else if (pop_cap) begin
        void'(mq.pop_front());
        mq.push_back(b);
      end else if (mq.size() < 4) mq.push_back(b);
      else ovr_m = 1;
    end
    check_state();
  endtask

  task automatic pop_check();
    check("pop_valid", rd_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("pop_data", rd_data, mq[0]);
      void'(mq.pop_front());
      rd_en = 1'b1;
      step();
    end
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    ferr_m = 0;
    ovr_m  = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_int", rx_int, 0);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_data", rd_data, 0);
    check_state();
    rst_n = 1'b1;
    rx_en = 1'b1;
    repeat (2) step();

    send_frame(8'hA5, 1'b1, 0, 0);

    // Start-bit glitch is rejected without any sample pulse.
    pulses.delete();
    step();
    rxd = 1'b0;
    n = cyc;
    step();
    check("glitch_busy", busy, 1);
    repeat (2) step();
    rxd = 1'b1;
    repeat (12) step();
    check("glitch_pulses", pulses.size(), 0);
    check_state();
    if (n < 0) check("cyc", n, 0);

    pop_check();
    send_frame(8'h3C, 1'b0, 0, 0);
    clear_errors();
    check_state();

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, 0);
    clear_errors();
    send_frame(8'h77, 1'b1, 1, 0);
    repeat (4) pop_check();
    check_state();

    rx_en = 1'b0;
    send_frame(8'h5A, 1'b1, 0, 0);
    rx_en = 1'b1;

`ifdef UART_RX_TIMEOUT_EN
    baud_div = 16'd16;
    send_frame(8'hC3, 1'b1, 0, 0);
    for (int i = 0; i < 2000 && !rx_timeout; i++) step();
    check("tmo_seen", rx_timeout, 1);
    check("tmo_delay", cyc - flag_cyc, 641);
    pop_check();
    check("tmo_clear", rx_timeout, 0);
`endif

    for (int it = 0; it < 20; it++) begin
      baud_div = 16'($urandom_range(0, 12));
      repeat ($urandom_range(0, 2)) pop_check();
      if ($urandom_range(0, 4) == 0) clear_errors();
      send_frame(8'($urandom), ($urandom_range(0, 5) != 0), 0, ($urandom_range(0, 1) == 1));
    end
    while (mq.size() != 0) pop_check();
    check_state();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
